// File: rtl/tx_frame_pkg.sv
// Shared types and constants for the transmit frame scheduler and its m-sequence generator.
// The TX_UNDERFLOW_ABORT_EN build option is consumed by tx_frame_sched.sv.
package tx_frame_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PREAMBLE,
        DATA,
        GAP
    } state_e;

    // x^5 + x^3 + 1: feedback is bit 4 xor bit 2, shifted into bit 0.
    localparam logic [4:0] LFSR_SEED   = 5'b00001;
    localparam int         LFSR_TAP_HI = 4;
    localparam int         LFSR_TAP_LO = 2;

    function automatic int midScale(input int width);
        return 1 << (width - 1);
    endfunction

    function automatic int cntWidth(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/tx_frame_sched_m_seq_gen.sv
// 5-bit Fibonacci LFSR m-sequence source; load has priority over step.
// Also intended as the local reference for the receiver's correlator.
module m_seq_gen
    import tx_frame_pkg::*;
(
    input  logic clk,
    input  logic arst_n,
    input  logic load_i,
    input  logic step_i,
    output logic chip_o
);

    logic [4:0] lfsr_q;
    logic [4:0] lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (load_i) begin
            lfsr_d = LFSR_SEED;
        end else if (step_i) begin
            lfsr_d = {lfsr_q[3:0], lfsr_q[LFSR_TAP_HI] ^ lfsr_q[LFSR_TAP_LO]};
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign chip_o = lfsr_q[4];

endmodule

// File: rtl/tx_frame_sched.sv
// Frames mapper samples as pilot preamble + LENGTH_DATA data + midscale guard gap for the DA.
// Build option TX_UNDERFLOW_ABORT_EN: a data hole ends the frame early instead of stalling.
module tx_frame_sched
    import tx_frame_pkg::*;
#(
    parameter int AD_CVER_WIDTH   = 12,
    parameter int LENGTH_DATA     = 1024,
    parameter int LENGTH_M_SEQ    = 31,
    parameter int GAP_LEN         = 16,
    parameter int PILOT_AMP       = 1024,
    parameter int FRAME_CNT_WIDTH = 16
) (
    input  logic                       clk,
    input  logic                       arst_n,
    input  logic                       tx_en,
    input  logic                       s_valid,
    output logic                       s_ready,
    input  logic [AD_CVER_WIDTH-1:0]   s_data,
    output logic [AD_CVER_WIDTH-1:0]   da_data,
    output logic                       da_frame,
    output logic                       da_pilot,
    output logic [FRAME_CNT_WIDTH-1:0] frame_cnt,
    output logic                       underflow
);

    localparam int MID     = midScale(AD_CVER_WIDTH);
    localparam int MAX_LEN = (LENGTH_DATA > LENGTH_M_SEQ)
                           ? ((LENGTH_DATA > GAP_LEN) ? LENGTH_DATA : GAP_LEN)
                           : ((LENGTH_M_SEQ > GAP_LEN) ? LENGTH_M_SEQ : GAP_LEN);
    localparam int CNT_W   = cntWidth(MAX_LEN);

    localparam logic [AD_CVER_WIDTH-1:0] MID_V    = AD_CVER_WIDTH'(MID);
    localparam logic [AD_CVER_WIDTH-1:0] PILOT_HI = AD_CVER_WIDTH'(MID + PILOT_AMP);
    localparam logic [AD_CVER_WIDTH-1:0] PILOT_LO = AD_CVER_WIDTH'(MID - PILOT_AMP);
    localparam logic [CNT_W-1:0] PRE_LAST  = CNT_W'(LENGTH_M_SEQ - 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(LENGTH_DATA - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_LEN - 1);

    if (PILOT_AMP >= MID) begin : gPilotAmpCheck
        $error("tx_frame_sched: PILOT_AMP must be below midscale");
    end
    if (GAP_LEN < 1) begin : gGapLenCheck
        $error("tx_frame_sched: GAP_LEN must be at least 1");
    end

    state_e                     state_q, state_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d;
    logic [FRAME_CNT_WIDTH-1:0] frame_cnt_q, frame_cnt_d;
    logic                       underflow_q, underflow_d;
    logic [AD_CVER_WIDTH-1:0]   da_data_q, da_data_d;
    logic                       da_frame_q, da_frame_d;
    logic                       da_pilot_q, da_pilot_d;
    logic                       lfsr_load;
    logic                       lfsr_step;
    logic                       chip;

    m_seq_gen u_m_seq_gen (
        .clk    (clk),
        .arst_n (arst_n),
        .load_i (lfsr_load),
        .step_i (lfsr_step),
        .chip_o (chip)
    );

    // One shared counter serves preamble chips, data samples and gap cycles; it restarts on every state change.
    // The LFSR is held at its seed whenever no preamble is running, so every preamble starts fresh.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        frame_cnt_d = frame_cnt_q;
        underflow_d = underflow_q;
        da_data_d   = MID_V;
        da_frame_d  = 1'b0;
        da_pilot_d  = 1'b0;
        lfsr_load   = 1'b1;
        lfsr_step   = 1'b0;
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (tx_en && s_valid) begin
                    state_d = PREAMBLE;
                end
            end
            PREAMBLE: begin
                lfsr_load  = 1'b0;
                lfsr_step  = 1'b1;
                da_frame_d = 1'b1;
                da_pilot_d = 1'b1;
                da_data_d  = chip ? PILOT_HI : PILOT_LO;
                if (cnt_q == PRE_LAST) begin
                    state_d = DATA;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DATA: begin
                da_frame_d = 1'b1;
                if (s_valid) begin
                    da_data_d = s_data;
                    if (cnt_q == DATA_LAST) begin
                        state_d     = GAP;
                        cnt_d       = '0;
                        frame_cnt_d = frame_cnt_q + 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end else begin
                    underflow_d = 1'b1;
`ifdef TX_UNDERFLOW_ABORT_EN
                    state_d = GAP;
                    cnt_d   = '0;
`endif
                end
            end
            GAP: begin
                if (cnt_q == GAP_LAST) begin
                    cnt_d   = '0;
                    state_d = (tx_en && s_valid) ? PREAMBLE : IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            frame_cnt_q <= '0;
            underflow_q <= 1'b0;
            da_data_q   <= MID_V;
            da_frame_q  <= 1'b0;
            da_pilot_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            frame_cnt_q <= frame_cnt_d;
            underflow_q <= underflow_d;
            da_data_q   <= da_data_d;
            da_frame_q  <= da_frame_d;
            da_pilot_q  <= da_pilot_d;
        end
    end

    assign s_ready   = (state_q == DATA);
    assign da_data   = da_data_q;
    assign da_frame  = da_frame_q;
    assign da_pilot  = da_pilot_q;
    assign frame_cnt = frame_cnt_q;
    assign underflow = underflow_q;

endmodule

// File: doc/tx_frame_sched.md
Name: tx_frame_sched

Overview:
Transmit frame scheduler between the PAM mapper sample stream and the DA/channel input of the synchroniser.
- Frames every block of LENGTH_DATA data samples as: m-sequence pilot preamble (LENGTH_M_SEQ chips), then data, then a midscale guard gap (GAP_LEN cycles).
- The receive-side correlator can therefore lock on every frame.
- Owns the DA output mux and the frame/underflow status.

Parameters:
AD_CVER_WIDTH, 12, DA sample width (offset binary)
LENGTH_DATA, 1024, data samples per frame
LENGTH_M_SEQ, 31, preamble chips (one m-sequence period, 5-bit LFSR)
GAP_LEN, 16, guard cycles after data, minimum 1
PILOT_AMP, 1024, chip amplitude about midscale
FRAME_CNT_WIDTH, 16, frame counter width

Ports:
clk  in  1  system clock
arst_n  in  1  asynchronous reset, active low
tx_en  in  1  enable frame starts; sampled only in IDLE and at end of GAP
s_valid  in  1  mapper sample valid
s_ready  out  1  sample accepted when s_valid&&s_ready
s_data  in  AD_CVER_WIDTH  mapper sample
da_data  out  AD_CVER_WIDTH  sample to DA/channel
da_frame  out  1  high during PREAMBLE and DATA output cycles
da_pilot  out  1  high during PREAMBLE output cycles
frame_cnt  out  FRAME_CNT_WIDTH  completed frames, wraps
underflow  out  1  sticky: s_valid low in DATA; cleared only by reset

Behaviour:
- Reset: state IDLE, da_data=MID (2^(AD_CVER_WIDTH-1)), s_ready=0, da_frame=0, da_pilot=0, frame_cnt=0, underflow=0, LFSR=5'b00001, counters 0.
- All outputs are registered. da_* reflect the state/sample of the previous clock, giving 1-cycle latency from sample acceptance to da_data.
- IDLE: da_data=MID. Go to PREAMBLE when tx_en && s_valid. Reseed LFSR to 5'b00001 on entry.
- PREAMBLE: exactly LENGTH_M_SEQ cycles, one chip per cycle.
  - chip = lfsr[4]; next lfsr = {lfsr[3:0], lfsr[4]^lfsr[2]} (x^5+x^3+1).
  - chip 1 -> MID+PILOT_AMP, chip 0 -> MID-PILOT_AMP. Arithmetic is in AD_CVER_WIDTH bits; PILOT_AMP < MID is required (elaboration-time check).
  - s_ready=0. Then go to DATA.
- DATA: s_ready=1 combinationally from state (not dependent on s_valid).
  - On s_valid: da_data<=s_data, data count+1.
  - On !s_valid: da_data<=MID, count holds, underflow<=1; with da_frame still 1.
  - When the LENGTH_DATA-th sample is accepted, go to GAP next cycle. s_ready drops in the same edge, so no extra sample is taken.
- GAP: GAP_LEN cycles of MID, da_frame=0. frame_cnt+1 on entry, wrapping from all-ones to 0. On the last GAP cycle: tx_en && s_valid -> PREAMBLE (back-to-back frames, no IDLE cycle), else IDLE.
- tx_en low mid-frame: frame completes normally, no truncation.
- Counter widths are $clog2 of the respective lengths; no counter exceeds its length-1.
- Async reset mid-frame returns to reset state immediately. No partial frame resumes.

Optional Feature:
TX_UNDERFLOW_ABORT_EN
- Defined: an underflow cycle in DATA sets underflow and moves directly to GAP. The remaining samples stay in the mapper and frame_cnt is not incremented for the aborted frame.
- Undefined: stall-with-midscale behaviour above; frame always carries LENGTH_DATA samples.

Decomposition:
- Package tx_frame_pkg:
  - state enum {IDLE, PREAMBLE, DATA, GAP}
  - MID constant function of AD_CVER_WIDTH
  - LFSR seed 5'b00001 and tap positions
- Sub-module m_seq_gen: 5-bit Fibonacci LFSR with load (seed) and step inputs and chip output. Reusable by the receiver's local correlator reference.

Test Plan:
- Reset, tx_en=1, s_valid=1 constant, LENGTH_DATA=8, GAP_LEN=4 -> 31 pilot cycles (first chips 0,0,0,0,1 = 1024,1024,1024,1024,3072; 16 at 3072, 15 at 1024), then 8 data samples in order, 4 cycles of 2048, frame_cnt=1, next preamble immediately.
- tx_en=0 with s_valid=1 -> stays IDLE, da_data=2048, s_ready=0, frame_cnt=0.
- s_valid dropped for 3 cycles mid-DATA -> 3 cycles da_data=2048 with da_frame=1, underflow=1 sticky, frame still carries 8 samples. With TX_UNDERFLOW_ABORT_EN -> enters GAP after the first hole, frame_cnt unchanged.
- tx_en cleared during PREAMBLE -> full frame completes, then IDLE after GAP.
- arst_n pulsed in DATA at sample 5 -> all outputs at reset values within the same cycle. Restart begins with a fresh preamble from seed 00001.
- FRAME_CNT_WIDTH=2, run 5 frames -> frame_cnt sequence 1,2,3,0,1.
